// File: rtl/multibyte_serial_adder.sv
// Byte-serial adder: adds two WORDS-byte operands through one shared 8-bit slice,
// carrying between bytes in a register so the combinational carry chain stays 8 bits.
module multibyte_serial_adder #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [8*WORDS-1:0] sum,
  output logic               cout
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     a_p0;
  logic [W-1:0]     b_p0;
  logic             carry_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [7:0]       a_byte_p0;
  logic [7:0]       b_byte_p0;
  logic [8:0]       slice_p0;

  function automatic logic [8:0] add_byte(input logic [7:0] x, input logic [7:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {8'd0, ci};
  endfunction

  // Stage 0: byte mux from the captured operands into the shared slice
  always_comb begin
    a_byte_p0 = '0;
    b_byte_p0 = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_p0 == IDX_W'(k)) begin
        a_byte_p0 = a_p0[8*k +: 8];
        b_byte_p0 = b_p0[8*k +: 8];
      end
    end
  end

  assign slice_p0 = add_byte(a_byte_p0, b_byte_p0, carry_p0);

  // Stage 1: slice result lands in its byte lane of sum, carry is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_p0     <= '0;
      b_p0     <= '0;
      carry_p0 <= 1'b0;
      idx_p0   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_p0     <= a;
            b_p0     <= b;
            carry_p0 <= cin;
            idx_p0   <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_p0 == IDX_W'(k)) sum[8*k +: 8] <= slice_p0[7:0];
          end
          carry_p0 <= slice_p0[8];
          if (idx_p0 == LAST_IDX) begin
            cout  <= slice_p0[8];
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx_p0 <= idx_p0 + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_serial_adder.sv
// Directed and random checks of multibyte_serial_adder at WORDS = 4, 2 and 8.
module tb_multibyte_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [31:0] a4 = '0, b4 = '0, sum4;
  logic        start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2;
  logic [15:0] a2 = '0, b2 = '0, sum2;
  logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [63:0] a8 = '0, b8 = '0, sum8;

  multibyte_serial_adder #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
  multibyte_serial_adder #(.WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));
  multibyte_serial_adder #(.WORDS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) tick();
    checks++;
    if ({busy4, done4, cout4} !== 3'b000 || sum4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b cout=%b sum=%h, required all 0",
               busy4, done4, cout4, sum4);
    end
    rst_n = 1'b1;
    tick();
    a4 = 32'hF0F0F0F0; b4 = 32'h1F1F1F1F; cin4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      tick();
      if (done4 === 1'b1) ok = 1;
    end
    checks++;
    if (!ok || sum4 !== 32'h10101010 || cout4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_preop done_seen=%0d sum=%h cout=%b, required sum=10101010 cout=1",
               ok, sum4, cout4);
    end
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, cout4} !== 3'b000 || sum4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_async busy=%b done=%b cout=%b sum=%h, required all 0 before edge",
               busy4, done4, cout4, sum4);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    int busy_cnt, done_cnt, done_at;
    logic [63:0] mask;
    logic [31:0] exp_part;
    a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (busy4 === 1'b1) busy_cnt++;
      if (done4 === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i <= 4) begin
        mask = (64'd1 << (8 * i)) - 64'd1;
        exp_part = 32'(64'h23456789 & mask);
        checks++;
        if (sum4 !== exp_part) begin
          failures++;
          $display("FAIL basic_partial step=%0d sum=%h, required %h", i, sum4, exp_part);
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt != 5) begin
      failures++;
      $display("FAIL basic_busy_len got=%0d required=5", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 4) begin
      failures++;
      $display("FAIL basic_done count=%0d at=%0d, required count=1 at=4", done_cnt, done_at);
    end
    checks++;
    if (sum4 !== 32'h23456789 || cout4 !== 1'b0) begin
      failures++;
      $display("FAIL basic_result sum=%h cout=%b, required 23456789/0", sum4, cout4);
    end
  endtask

  task automatic test_carry_ripple();
    a4 = 32'hFFFFFFFF; b4 = 32'h00000000; cin4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (dut4.carry_p0 !== 1'b1 || sum4 !== 32'h0) begin
        failures++;
        $display("FAIL ripple_byte%0d carry=%b sum=%h, required carry=1 sum=0",
                 k, dut4.carry_p0, sum4);
      end
    end
    checks++;
    if (done4 !== 1'b1 || cout4 !== 1'b1 || sum4 !== 32'h0) begin
      failures++;
      $display("FAIL ripple_final done=%b cout=%b sum=%h, required 1/1/00000000",
               done4, cout4, sum4);
    end
    repeat (2) tick();
  endtask

  task automatic test_isolation();
    int done_cnt;
    a4 = 32'h80000000; b4 = 32'h80000000; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 32'hFFFFFFFF; b4 = 32'hFFFFFFFF; cin4 = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done4 === 1'b1) done_cnt++;
      start4 = (i == 2);
      tick();
    end
    start4 = 1'b0;
    checks++;
    if (done_cnt != 1 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL isolation_done count=%0d busy=%b, required 1 pulse and idle", done_cnt, busy4);
    end
    checks++;
    if (sum4 !== 32'h0 || cout4 !== 1'b1) begin
      failures++;
      $display("FAIL isolation_result sum=%h cout=%b, required 00000000/1", sum4, cout4);
    end
  endtask

  task automatic test_reset_midop();
    int done_cnt;
    bit ok;
    a4 = 32'h01010101; b4 = 32'h01010101; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, cout4} !== 3'b000 || sum4 !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset busy=%b done=%b cout=%b sum=%h, required all 0",
               busy4, done4, cout4, sum4);
    end
    done_cnt = 0;
    repeat (2) begin
      tick();
      if (done4 === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (done4 === 1'b1 || busy4 === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL midop_no_done activity=%0d, required 0", done_cnt);
    end
    a4 = 32'h00000001; b4 = 32'h00000001; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      tick();
      if (done4 === 1'b1) ok = 1;
    end
    checks++;
    if (!ok || sum4 !== 32'h2 || cout4 !== 1'b0) begin
      failures++;
      $display("FAIL midop_after done_seen=%0d sum=%h cout=%b, required 00000002/0",
               ok, sum4, cout4);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back_w2();
    logic [15:0] ea, eb;
    logic ec;
    logic [16:0] exp;
    int last_acc, acc;
    bit ok;
    last_acc = -1;
    for (int n = 0; n < 1000; n++) begin
      ea = 16'($urandom); eb = 16'($urandom); ec = 1'($urandom_range(0, 1));
      a2 = ea; b2 = eb; cin2 = ec; start2 = 1'b1;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        tick();
        if (busy2 === 1'b1) ok = 1;
      end
      acc = cyc;
      a2 = ~ea; b2 = ~eb; cin2 = ~ec;
      if (!ok) begin
        checks++; failures++;
        $display("FAIL w2_accept op=%0d busy never rose", n);
      end else if (last_acc >= 0) begin
        checks++;
        if (acc - last_acc != 4) begin
          failures++;
          $display("FAIL w2_interval op=%0d got=%0d required=4", n, acc - last_acc);
        end
      end
      last_acc = acc;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        tick();
        if (done2 === 1'b1) ok = 1;
      end
      exp = {1'b0, ea} + {1'b0, eb} + 17'(ec);
      checks++;
      if (!ok || {cout2, sum2} !== exp) begin
        failures++;
        $display("FAIL w2_result op=%0d done_seen=%0d got=%h required=%h",
                 n, ok, {cout2, sum2}, exp);
      end
      tick();
    end
    start2 = 1'b0;
  endtask

  task automatic test_back_to_back_w8();
    logic [63:0] ea, eb;
    logic ec;
    logic [64:0] exp;
    int last_acc, acc;
    bit ok;
    last_acc = -1;
    for (int n = 0; n < 1000; n++) begin
      ea = {$urandom, $urandom}; eb = {$urandom, $urandom}; ec = 1'($urandom_range(0, 1));
      a8 = ea; b8 = eb; cin8 = ec; start8 = 1'b1;
      ok = 0;
      for (int t = 0; t < 30 && !ok; t++) begin
        tick();
        if (busy8 === 1'b1) ok = 1;
      end
      acc = cyc;
      a8 = ~ea; b8 = ~eb; cin8 = ~ec;
      if (!ok) begin
        checks++; failures++;
        $display("FAIL w8_accept op=%0d busy never rose", n);
      end else if (last_acc >= 0) begin
        checks++;
        if (acc - last_acc != 10) begin
          failures++;
          $display("FAIL w8_interval op=%0d got=%0d required=10", n, acc - last_acc);
        end
      end
      last_acc = acc;
      ok = 0;
      for (int t = 0; t < 30 && !ok; t++) begin
        tick();
        if (done8 === 1'b1) ok = 1;
      end
      exp = {1'b0, ea} + {1'b0, eb} + 65'(ec);
      checks++;
      if (!ok || {cout8, sum8} !== exp) begin
        failures++;
        $display("FAIL w8_result op=%0d done_seen=%0d got=%h required=%h",
                 n, ok, {cout8, sum8}, exp);
      end
      tick();
    end
    start8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_isolation();
    test_reset_midop();
    test_back_to_back_w2();
    test_back_to_back_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
